// File: rtl/stage_reg_gen_pkg.sv
// stage_reg_gen_pkg: shared stage indices, stall width, action encoding and zero-register constant
package stage_reg_gen_pkg;
  localparam int STALL_W_DEF = 6;
  localparam int STG_IF      = 0;
  localparam int STG_ID      = 1;
  localparam int STG_EX      = 2;
  localparam int STG_MEM     = 3;
  localparam int STG_MEMWB   = 4;
  localparam int STG_WB      = 5;
  localparam int ZERO_ADDR   = 0;
  typedef enum logic [2:0] {ACT_RST, ACT_FLUSH, ACT_BUBBLE, ACT_PASS, ACT_HOLD} act_e;
endpackage

// File: rtl/stage_reg_gen_we_resolve.sv
// we_resolve: per-channel write-enable filter for zero-register writes and same-address collisions
module we_resolve
  import stage_reg_gen_pkg::*;
#(
  parameter int NCH      = 1,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [NCH-1:0]    we,
  input  logic [NCH*AW-1:0] addr,
  output logic [NCH-1:0]    we_out
);
  // a channel loses its enable to a higher-index channel writing the same address
  always_comb begin
    we_out = '0;
    for (int i = 0; i < NCH; i++) begin
      we_out[i] = we[i] && !(ZERO_REG && addr[i*AW +: AW] == AW'(ZERO_ADDR));
      for (int j = i + 1; j < NCH; j++)
        if (we[j] && addr[j*AW +: AW] == addr[i*AW +: AW]) we_out[i] = 1'b0;
    end
  end
endmodule

// File: rtl/stage_reg_gen.sv
// stage_reg_gen: stall-aware inter-stage register with write-back channels; STAGE_REG_RETIRE_CNT_EN enables retire_cnt
module stage_reg_gen
  import stage_reg_gen_pkg::*;
#(
  parameter int DW        = 32,
  parameter int AW        = 5,
  parameter int NCH       = 1,
  parameter int PC_W      = 32,
  parameter int STALL_W   = STALL_W_DEF,
  parameter int STAGE_IDX = STG_MEMWB,
  parameter bit ZERO_REG  = 1'b1,
  parameter int HOLD_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [NCH*DW-1:0]   in_wdata,
  input  logic [NCH*AW-1:0]   in_waddr,
  input  logic [NCH-1:0]      in_we,
  output logic                out_valid,
  output logic [PC_W-1:0]     out_pc,
  output logic [NCH*DW-1:0]   out_wdata,
  output logic [NCH*AW-1:0]   out_waddr,
  output logic [NCH-1:0]      out_we,
  output logic [HOLD_W-1:0]   hold_cnt,
  output logic [63:0]         retire_cnt
);
  act_e           act;
  logic [NCH-1:0] we_res;
  logic           unused_stall;
  assign unused_stall = ^stall;
  we_resolve #(.NCH(NCH), .AW(AW), .ZERO_REG(ZERO_REG)) u_res (
    .we     (in_we & {NCH{in_valid}}),
    .addr   (in_waddr),
    .we_out (we_res)
  );
  // edge action by priority; upstream-run with downstream-stalled is treated as pass
  always_comb
    act = rst ? ACT_RST : flush ? ACT_FLUSH : !stall[STAGE_IDX] ? ACT_PASS :
          stall[STAGE_IDX+1] ? ACT_HOLD : ACT_BUBBLE;
  // payload register: capture on pass, keep on hold, clear otherwise
  always_ff @(posedge clk)
    if (act == ACT_PASS) begin
      out_valid <= in_valid;
      out_pc    <= in_pc;
      out_wdata <= in_wdata;
      out_waddr <= in_waddr;
      out_we    <= we_res;
    end else if (act != ACT_HOLD) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_wdata <= '0;
      out_waddr <= '0;
      out_we    <= '0;
    end
  // consecutive hold cycles, saturating
  always_ff @(posedge clk)
    hold_cnt <= act == ACT_HOLD ? hold_cnt + HOLD_W'(hold_cnt != '1) : '0;
`ifdef STAGE_REG_RETIRE_CNT_EN
  // count valid instructions passing through this stage
  always_ff @(posedge clk)
    retire_cnt <= act == ACT_RST ? '0 : retire_cnt + 64'(act == ACT_PASS && in_valid);
`else
  assign retire_cnt = '0;
`endif
endmodule

// File: tb/tb_stage_reg_gen.sv
// tb_stage_reg_gen: directed self-checking bench for stage_reg_gen with two channels
module tb_stage_reg_gen;
  localparam int NCH = 2;
`ifdef STAGE_REG_RETIRE_CNT_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst, flush, in_valid;
  logic [5:0]    stall;
  logic [31:0]   in_pc, out_pc;
  logic [63:0]   in_wdata, out_wdata;
  logic [9:0]    in_waddr, out_waddr;
  logic [1:0]    in_we, out_we;
  logic          out_valid;
  logic [7:0]    hold_cnt;
  logic [63:0]   retire_cnt;
  int vecs = 0;
  int errs = 0;

  stage_reg_gen #(.NCH(NCH)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_wdata(in_wdata), .in_waddr(in_waddr), .in_we(in_we),
    .out_valid(out_valid), .out_pc(out_pc), .out_wdata(out_wdata),
    .out_waddr(out_waddr), .out_we(out_we), .hold_cnt(hold_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_clear(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_pc"}, 64'(out_pc), 64'd0);
    chk({tag, "_wdata"}, out_wdata, 64'd0);
    chk({tag, "_waddr"}, 64'(out_waddr), 64'd0);
    chk({tag, "_we"}, 64'(out_we), 64'd0);
    chk({tag, "_hold"}, 64'(hold_cnt), 64'd0);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [63:0] d,
                       input logic [9:0] a, input logic [1:0] we);
    in_valid = v; in_pc = pc; in_wdata = d; in_waddr = a; in_we = we;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0;
    drive(1'b1, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 10'h3FF, 2'b11);
    step(); step();
    chk_clear("reset");
    chk("reset_retire", retire_cnt, 64'd0);

    rst = 1'b0;
    drive(1'b1, 32'h40, {32'h0, 32'hDEAD_BEEF}, {5'd0, 5'd3}, 2'b01);
    step();
    chk("pass_pc", 64'(out_pc), 64'h40);
    chk("pass_waddr", 64'(out_waddr), 64'd3);
    chk("pass_wdata", out_wdata, 64'hDEAD_BEEF);
    chk("pass_we", 64'(out_we), 64'd1);
    chk("pass_valid", 64'(out_valid), 64'd1);
    chk("pass_retire", retire_cnt, RC ? 64'd1 : 64'd0);

    stall = 6'b010000;
    step();
    chk_clear("bubble");

    stall = '0;
    drive(1'b1, 32'h44, {32'h0, 32'h1234_5678}, {5'd0, 5'd5}, 2'b01);
    step();
    stall = 6'b110000;
    drive(1'b1, 32'h999, 64'hAAAA_AAAA_AAAA_AAAA, 10'h2AA, 2'b11);
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300)
        chk($sformatf("hold_cnt_%0d", k), 64'(hold_cnt), k < 255 ? 64'(k) : 64'd255);
    end
    chk("hold_pc", 64'(out_pc), 64'h44);
    chk("hold_wdata", out_wdata, 64'h1234_5678);
    chk("hold_waddr", 64'(out_waddr), 64'd5);
    chk("hold_we", 64'(out_we), 64'd1);
    chk("hold_valid", 64'(out_valid), 64'd1);

    stall = '0;
    drive(1'b0, 32'h48, 64'h5, {5'd2, 5'd1}, 2'b11);
    step();
    chk("unhold_cnt", 64'(hold_cnt), 64'd0);
    chk("invalid_valid", 64'(out_valid), 64'd0);
    chk("invalid_we", 64'(out_we), 64'd0);
    chk("invalid_waddr", 64'(out_waddr), {54'd0, 5'd2, 5'd1});

    drive(1'b1, 32'h50, {32'h22, 32'h11}, {5'd7, 5'd7}, 2'b11);
    step();
    chk("collide_we", 64'(out_we), 64'b10);
    chk("collide_wdata", out_wdata, {32'h22, 32'h11});

    drive(1'b1, 32'h54, {32'h22, 32'h11}, {5'd9, 5'd7}, 2'b11);
    step();
    chk("distinct_we", 64'(out_we), 64'b11);

    drive(1'b1, 32'h58, {32'h33, 32'h44}, {5'd4, 5'd0}, 2'b11);
    step();
    chk("zero_reg_we", 64'(out_we), 64'b10);

    drive(1'b1, 32'h5C, {32'h33, 32'h44}, {5'd0, 5'd6}, 2'b01);
    step();
    chk("zero_ch1_off_we", 64'(out_we), 64'b01);

    stall = 6'b110000;
    step(); step();
    chk("pre_flush_hold", 64'(hold_cnt), 64'd2);
    flush = 1'b1;
    step();
    chk_clear("flush_over_hold");
    flush = 1'b0;

    stall = 6'b100000;
    drive(1'b1, 32'h80, {32'h0, 32'h77}, {5'd0, 5'd8}, 2'b01);
    step();
    chk("illegal_pass_pc", 64'(out_pc), 64'h80);
    chk("illegal_pass_we", 64'(out_we), 64'd1);

    stall = 6'b110000;
    step(); step(); step();
    rst = 1'b1;
    step();
    chk_clear("mid_reset");
    chk("mid_reset_retire", retire_cnt, 64'd0);
    rst = 1'b0;

    stall = '0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), 64'(k), {5'd0, 5'(k + 1)}, 2'b01);
      step();
    end
    stall = 6'b010000;
    step(); step(); step();
    stall = '0; flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h200, 64'h0, 10'd1, 2'b01);
    step(); step();
    chk("retire_final", retire_cnt, RC ? 64'd10 : 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/stage_reg_gen.md
Name: stage_reg_gen

Overview:
- Parametrised inter-stage pipeline register; the next generation of the MEM/WB latch.
- Carries PC, a valid bit and NCH independent register write-back channels between stage STAGE_IDX and STAGE_IDX+1.
- Applies the 6-bit stall-vector protocol (bubble / pass / hold), plus an explicit flush.
- Adds write-collision resolution, zero-register write suppression and a hold watchdog counter.

Parameters:
- DW, 32, data width per channel
- AW, 5, register-address width per channel
- NCH, 1, number of write-back channels (e.g. 2 for GPR plus HI/LO)
- PC_W, 32, PC width
- STALL_W, 6, stall vector width
- STAGE_IDX, 4, stall bit owned by this register; stall[STAGE_IDX+1] is downstream; legal range 0..STALL_W-2
- ZERO_REG, 1, 1 = a write to address 0 is suppressed on every channel
- HOLD_W, 8, width of the hold counter

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  STALL_W  pipeline stall vector
- flush  in  1  exception/branch flush of this stage
- in_valid  in  1  upstream slot holds a real instruction
- in_pc  in  PC_W  upstream PC
- in_wdata  in  NCH*DW  write data; channel i occupies [i*DW +: DW]
- in_waddr  in  NCH*AW  write address per channel
- in_we  in  NCH  write enable per channel
- out_valid  out  1  registered valid
- out_pc  out  PC_W  registered PC
- out_wdata  out  NCH*DW  registered write data
- out_waddr  out  NCH*AW  registered write address
- out_we  out  NCH  registered, resolved write enables
- hold_cnt  out  HOLD_W  consecutive hold cycles, saturating
- retire_cnt  out  64  retired-instruction count (see Optional Feature)

Behaviour:
- Single clock domain. All outputs registered; latency 1 cycle on pass.
- Per-edge priority: rst > flush > bubble > pass > hold.
- rst: every output 0, including hold_cnt and retire_cnt.
- flush: all data outputs and out_valid cleared to 0, regardless of stall; hold_cnt set to 0.
- bubble (stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=0): same clearing as flush; hold_cnt set to 0.
- pass (stall[STAGE_IDX]=0): capture all inputs; hold_cnt set to 0.
- hold (stall[STAGE_IDX]=1 and stall[STAGE_IDX+1]=1): all data outputs keep their value; hold_cnt increments, saturating at 2^HOLD_W-1 with no wrap.
- Write-enable resolution on pass, using the captured values:
  - we_i = in_we[i] & in_valid.
  - If ZERO_REG=1 and waddr_i==0, clear we_i.
  - If channels i<j both have we set with equal waddr, clear we_i (higher index wins).
  - Resolution is purely combinational ahead of the flops.
- out_wdata and out_waddr are captured even when the corresponding out_we is 0; consumers must qualify on out_we.
- stall[STAGE_IDX]=0 with stall[STAGE_IDX+1]=1 is an illegal upstream condition; treat it as pass.
- flush and hold in the same cycle: flush wins.
- Mid-operation rst clears everything on that edge; no state survives it.

Optional Feature:
- Macro: STAGE_REG_RETIRE_CNT_EN.
- Defined: retire_cnt is a 64-bit counter.
  - Increments by 1 on every pass edge whose captured in_valid=1.
  - Does not count on flush, bubble or hold.
  - Wraps modulo 2^64; reset to 0.
- Not defined: retire_cnt is tied to constant 0 and no counter flops are inferred.

Decomposition:
- Shared package: stall-vector width and stage indices (IF=0..WB=5); action encoding (ACT_RST, ACT_FLUSH, ACT_BUBBLE, ACT_PASS, ACT_HOLD); zero-register address constant.
- Sub-module we_resolve: combinational NCH-channel collision and zero-register filter; parametrised by NCH, AW, ZERO_REG.

Test Plan:
- Reset then pass: rst=1 for 2 cycles, then stall=0, in_valid=1, in_pc=0x0000_0040, in_waddr=3, in_wdata=0xDEAD_BEEF, in_we=1 -> after 1 edge: out_pc=0x40, out_waddr=3, out_wdata=0xDEADBEEF, out_we=1, out_valid=1.
- Bubble: stall=6'b010000 with STAGE_IDX=4 -> next edge all outputs 0, out_valid=0, hold_cnt=0.
- Hold and saturate: stall=6'b110000 held 300 cycles after a valid pass -> outputs unchanged; hold_cnt=255 at cycle 255 and stays 255; stall=0 -> hold_cnt=0.
- Collision: NCH=2, both in_we=1, both waddr=7, data 0x11 / 0x22 -> out_we=2'b10, out_wdata channel1=0x22.
- Zero register and flush: waddr=0, in_we=1 -> out_we=0. flush=1 together with stall=6'b110000 -> outputs cleared, not held.
- Retire count (macro defined): 10 valid passes, 3 bubbles, 1 flush, 2 invalid passes -> retire_cnt=10. Macro undefined -> retire_cnt=0 throughout.
